// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the async FIFO (write clock domain).
// Accepts a valid/ready stream, drives the RAM write port, owns the binary
// write pointer and derives full / almost_full / level against the
// synchronized read pointer.
module fifo_wr_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AFULL_TH   = 12,
  parameter int unsigned HOLD_CYC   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  ptr_err
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               ovf_q, ovf_d;
  logic               ptr_err_q, ptr_err_d;
  logic               ready_c;
  logic               accept_c;
  logic [PTR_W-1:0]   lvl_next_c;

  // Handshake and RAM write port; ready is derived from registered state only.
  always_comb begin
    ready_c  = (state_q == RUN) && !full_q;
    accept_c = s_valid && ready_c;
  end

  assign s_ready     = ready_c;
  assign ram_we      = accept_c;
  assign ram_waddr   = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata   = s_data;
  assign wr_ptr      = wr_ptr_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign ovf         = ovf_q;
  assign ptr_err     = ptr_err_q;

  // State, counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ptr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      ptr_err_q  <= ptr_err_d;
    end
  end

  // Next-state: hold-off sequencing, pointer advance and level/flag update.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    ptr_err_d  = ptr_err_q;

    // Keep s_ready low long enough for the unreset read-pointer synchronizer to flush.
    case (state_q)
      HOLD: begin
        if (hold_cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    wr_ptr_d   = wr_ptr_q + PTR_W'(accept_c);
    // Read pointer lags, so this level is never an underestimate.
    lvl_next_c = wr_ptr_d - rd_ptr_sync;
    level_d    = lvl_next_c;
    // Anything above DEPTH is an illegal relation; treat it as full too.
    full_d     = (lvl_next_c >= PTR_W'(DEPTH));
    afull_d    = (lvl_next_c >= PTR_W'(AFULL_TH));
    if (lvl_next_c > PTR_W'(DEPTH)) begin
      ptr_err_d = 1'b1;
    end

    // Set beats clear when both happen in the same cycle.
    if ((state_q == RUN) && s_valid && !ready_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: hold-off, fill, drain step, wrap,
// overflow flag, pointer error and asynchronous reset.
module tb_fifo_wr_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW:0]   rd_ptr_sync;
  logic [AW:0]   wr_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          ovf;
  logic          ovf_clr;
  logic          ptr_err;

  int checks;
  int passed;
  int wm;

  fifo_wr_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_TH  (12),
    .HOLD_CYC  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .rd_ptr_sync(rd_ptr_sync),
    .wr_ptr     (wr_ptr),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .ptr_err    (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".s_ready"}, 32'(s_ready), 0);
    check({tag, ".ram_we"}, 32'(ram_we), 0);
    check({tag, ".wr_ptr"}, 32'(wr_ptr), 0);
    check({tag, ".full"}, 32'(full), 0);
    check({tag, ".afull"}, 32'(almost_full), 0);
    check({tag, ".level"}, 32'(wr_level), 0);
    check({tag, ".ovf"}, 32'(ovf), 0);
    check({tag, ".ptr_err"}, 32'(ptr_err), 0);
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    rst         = 1'b1;
    s_valid     = 1'b1;
    s_data      = '0;
    rd_ptr_sync = '0;
    ovf_clr     = 1'b0;
    step();
    step();
    check_all_zero("reset");

    // Release reset with s_valid held high: three hold cycles, no ovf.
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d.s_ready", c), 32'(s_ready), 0);
      check($sformatf("hold%0d.ram_we", c), 32'(ram_we), 0);
      step();
      check($sformatf("hold%0d.ovf", c), 32'(ovf), 0);
    end

    // 16 back-to-back writes with read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      s_data = 8'(8'hA0 + i);
      #1;
      check($sformatf("fill%0d.ram_we", i), 32'(ram_we), 1);
      check($sformatf("fill%0d.waddr", i), 32'(ram_waddr), 32'(i));
      check($sformatf("fill%0d.wdata", i), 32'(ram_wdata), 32'(8'hA0 + i));
      step();
      check($sformatf("fill%0d.wr_ptr", i), 32'(wr_ptr), 32'(i + 1));
      check($sformatf("fill%0d.level", i), 32'(wr_level), 32'(i + 1));
      check($sformatf("fill%0d.afull", i), 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      check($sformatf("fill%0d.full", i), 32'(full), (i + 1 == 16) ? 1 : 0);
      check($sformatf("fill%0d.ovf", i), 32'(ovf), 0);
    end
    #1;
    check("full.s_ready", 32'(s_ready), 0);
    check("full.no17th_we", 32'(ram_we), 0);
    s_valid = 1'b0;

    // One slot freed: full drops one edge later, one more write refills.
    rd_ptr_sync = 5'd1;
    step();
    check("free.full", 32'(full), 0);
    check("free.level", 32'(wr_level), 15);
    s_valid = 1'b1;
    s_data  = 8'h5C;
    #1;
    check("refill.ram_we", 32'(ram_we), 1);
    check("refill.waddr", 32'(ram_waddr), 0);
    step();
    s_valid = 1'b0;
    check("refill.wr_ptr", 32'(wr_ptr), 17);
    check("refill.full", 32'(full), 1);
    check("refill.level", 32'(wr_level), 16);

    // Read pointer trails by two; 40 writes wrap the pointer.
    rd_ptr_sync = 5'd15;
    step();
    check("trail.level", 32'(wr_level), 2);
    check("trail.full", 32'(full), 0);
    wm = 17;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rd_ptr_sync = 5'((wm - 1) % 32);
      s_data      = 8'(i);
      #1;
      check($sformatf("wrap%0d.waddr", i), 32'(ram_waddr), 32'(wm % 16));
      check($sformatf("wrap%0d.ram_we", i), 32'(ram_we), 1);
      step();
      wm = (wm + 1) % 32;
      check($sformatf("wrap%0d.wr_ptr", i), 32'(wr_ptr), 32'(wm));
      check($sformatf("wrap%0d.level", i), 32'(wr_level), 2);
      check($sformatf("wrap%0d.ptr_err", i), 32'(ptr_err), 0);
    end
    check("wrap.end_ptr", 32'(wr_ptr), 25);

    // Fill again across the wrap with read pointer held at 23.
    rd_ptr_sync = 5'd23;
    for (int i = 0; i < 14; i++) begin
      step();
    end
    s_valid = 1'b0;
    check("refull.wr_ptr", 32'(wr_ptr), 7);
    check("refull.level", 32'(wr_level), 16);
    check("refull.full", 32'(full), 1);
    check("refull.ovf", 32'(ovf), 0);

    // Overflow flag: set, set-wins-over-clear, then clear.
    s_valid = 1'b1;
    step();
    check("ovf.set", 32'(ovf), 1);
    check("ovf.wr_ptr", 32'(wr_ptr), 7);
    ovf_clr = 1'b1;
    step();
    check("ovf.set_wins", 32'(ovf), 1);
    s_valid = 1'b0;
    step();
    ovf_clr = 1'b0;
    check("ovf.cleared", 32'(ovf), 0);

    // Read pointer ahead of write pointer.
    rd_ptr_sync = 5'd8;
    step();
    check("perr.ptr_err", 32'(ptr_err), 1);
    check("perr.full", 32'(full), 1);
    check("perr.level", 32'(wr_level), 31);
    rd_ptr_sync = 5'd23;
    step();
    check("perr.sticky", 32'(ptr_err), 1);

    // Fresh start, burst, then asynchronous reset mid-burst.
    rst = 1'b1;
    #1;
    check_all_zero("rst1");
    rd_ptr_sync = '0;
    step();
    rst     = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
    end
    check("burst.wr_ptr", 32'(wr_ptr), 3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rehold%0d.s_ready", c), 32'(s_ready), 0);
      step();
    end
    #1;
    check("rerun.s_ready", 32'(s_ready), 1);
    check("rerun.ram_we", 32'(ram_we), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side controller for the team's asynchronous FIFO, running entirely in the write clock domain. Accepts a valid/ready write stream and drives the dual-port RAM write port. Maintains the (ADDR_WIDTH+1)-bit binary write pointer that feeds the pointer clock-crossing block. Computes full, almost-full and fill level against the read pointer, which arrives already synchronized and decoded to binary.

## Interface
- DATA_WIDTH, 8, width of write data
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
- AFULL_TH, 12, almost_full threshold in entries (1..DEPTH)
- HOLD_CYC, 3, cycles s_ready is held low after reset release (≥2, covers the unreset 2-flop crossing synchronizer)

Ports:
- clk  in  1  write-domain clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  write request
- s_data  in  DATA_WIDTH  write data
- s_ready  out  1  controller can accept
- ram_we  out  1  RAM write enable (combinational, = s_valid & s_ready)
- ram_waddr  out  ADDR_WIDTH  = wr_ptr[ADDR_WIDTH-1:0]
- ram_wdata  out  DATA_WIDTH  = s_data
- rd_ptr_sync  in  ADDR_WIDTH+1  binary read pointer, already in clk domain
- wr_ptr  out  ADDR_WIDTH+1  binary write pointer, to crossing block
- full  out  1  registered
- almost_full  out  1  registered
- wr_level  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
- ovf  out  1  sticky: write attempted while not ready
- ovf_clr  in  1  clears ovf
- ptr_err  out  1  sticky: pointer relation illegal

## Operation
- FSM states: HOLD, RUN. Async reset → HOLD, hold counter = 0.
- HOLD: s_ready=0; counter increments each cycle; at counter==HOLD_CYC-1 → RUN next edge.
- RUN: s_ready = ~full. Stays in RUN until reset.
- Accept = s_valid & s_ready; on accept, wr_ptr <= wr_ptr+1, wrapping modulo 2**(ADDR_WIDTH+1). RAM captures data at the same edge.
- wr_ptr_next = wr_ptr + accept.
- lvl_next = (wr_ptr_next - rd_ptr_sync) mod 2**(ADDR_WIDTH+1).
- Each edge: wr_level <= lvl_next, full <= (lvl_next == DEPTH), almost_full <= (lvl_next >= AFULL_TH).
  - Pessimistic by design: rd_ptr_sync lags and only advances, so the level is never underestimated.
  - full may deassert one cycle later than ideal. It must never be low while DEPTH entries are held.
- ptr_err sets when lvl_next > DEPTH (read pointer ahead of write pointer, or overrun). Cleared only by rst. When lvl_next > DEPTH, full is forced to 1.
- ovf sets when s_valid & ~s_ready in RUN. s_valid during HOLD does not set ovf.
- ovf_clr clears ovf; simultaneous set and clear → set wins.
- No writes to RAM when s_ready=0, regardless of s_valid.

## Timing
- Reset values: s_ready=0, wr_ptr=0, full=0, almost_full=0, wr_level=0, ovf=0, ptr_err=0. ram_we=0 while in HOLD.
- First accept is possible at edge HOLD_CYC after rst deasserts.
- Write latency: data is in RAM and wr_ptr is updated at the accepting edge.
- full rises at the edge that accepts entry DEPTH. s_ready drops the same cycle, so back-to-back writes stop with no overrun.
- full falls one edge after rd_ptr_sync shows a free slot.
- Wrap: wr_ptr goes from 2**(ADDR_WIDTH+1)-1 to 0. ram_waddr wraps at DEPTH. Level arithmetic stays correct across the wrap.
- Simultaneous accept and rd_ptr_sync advance: level is unchanged.
- rst asserted mid-burst: all outputs return to reset values immediately (async); the FSM re-enters HOLD.

## Test plan
- Reset release, s_valid=1 continuously, HOLD_CYC=3 → s_ready low for 3 cycles, first ram_we at cycle 3, ovf stays 0.
- rd_ptr_sync=0, 16 back-to-back writes → wr_level reaches 16, almost_full rises after the 12th accept, full after the 16th, s_ready=0, wr_ptr=16, no 17th ram_we.
- From full, rd_ptr_sync steps to 1 → full=0 one edge later, one write accepted at ram_waddr=0, wr_ptr=17, full=1 again.
- Run 40 writes with rd_ptr_sync tracking wr_ptr−2 → wr_ptr wraps 31→0, wr_level stays 2, ptr_err=0.
- While full, drive s_valid=1 → ovf=1. Pulse ovf_clr together with s_valid (set wins) → ovf stays 1. ovf_clr alone → ovf=0.
- Drive rd_ptr_sync = wr_ptr+1 → ptr_err=1 and full=1 next edge. Assert rst mid-burst → all outputs are 0 immediately and HOLD is re-entered.
